// File: rtl/blk_msg_tx.sv
// Framed-message UART transmitter: 0x30 0x31 LEN payload CHK 0x32, each byte sent 8N1 LSB first.
// Latency: start bit of the first byte begins the cycle after an accepted i_start; o_done one cycle after the last stop bit.
// Backpressure: none; i_start is ignored while busy, oversize requests pulse o_err. Option MSG_TX_GAP_EN adds an idle bit after each byte.
module blk_msg_tx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int MAX_PAYLOAD  = 250
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [9:0] i_len,
    output logic       o_mem_en,
    output logic [9:0] o_mem_raddr,
    input  logic [7:0] i_mem_rdata,
    output logic       o_uart_tx,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err
);

    localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);
    localparam logic [9:0]  MAX_LEN  = 10'(MAX_PAYLOAD);

    typedef enum logic [2:0] {
        B_IDLE, B_HDR0, B_HDR1, B_LEN, B_PAY, B_CHK, B_TRL
    } byte_st_t;

    typedef enum logic [1:0] {
        T_START, T_DATA, T_STOP, T_GAP
    } bit_st_t;

    byte_st_t    r_byte_st, w_byte_st;
    bit_st_t     r_bit_st,  w_bit_st;
    logic [15:0] r_baud,    w_baud;
    logic [2:0]  r_bit_idx, w_bit_idx;
    logic [7:0]  r_shift,   w_shift;
    logic [7:0]  r_next,    w_next;
    logic [7:0]  r_chk,     w_chk;
    logic [9:0]  r_len,     w_len;
    logic [9:0]  r_pay_cnt, w_pay_cnt;
    logic        r_cap,     w_cap;
    logic        r_tx,      w_tx;
    logic        r_busy,    w_busy;
    logic        r_done,    w_done;
    logic        r_err,     w_err;
    logic        r_mem_en,  w_mem_en;
    logic [9:0]  r_raddr,   w_raddr;

    // Byte-load request shared by the IDLE accept path and the byte sequencer
    logic        w_load;
    logic        w_chk_en;
    logic [7:0]  w_load_byte;
    byte_st_t    w_load_st;
    logic        w_byte_end;
    logic [7:0]  w_len_byte;

    assign w_len_byte = r_len[7:0] + 8'd5;

    // Next-state logic for the byte sequencer, bit serializer, prefetch and checksum
    always_comb begin
        w_byte_st   = r_byte_st;
        w_bit_st    = r_bit_st;
        w_baud      = r_baud;
        w_bit_idx   = r_bit_idx;
        w_shift     = r_shift;
        w_next      = r_cap ? i_mem_rdata : r_next;
        w_chk       = r_chk;
        w_len       = r_len;
        w_pay_cnt   = r_pay_cnt;
        w_cap       = r_mem_en;
        w_tx        = r_tx;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_mem_en    = 1'b0;
        w_raddr     = r_raddr;
        w_load      = 1'b0;
        w_chk_en    = 1'b0;
        w_load_byte = 8'h00;
        w_load_st   = r_byte_st;
        w_byte_end  = 1'b0;

        if (r_byte_st == B_IDLE) begin
            if (i_start) begin
                if (i_len > MAX_LEN) begin
                    w_err = 1'b1;
                end else begin
                    w_len       = i_len;
                    w_chk       = 8'h00;
                    w_busy      = 1'b1;
                    w_load      = 1'b1;
                    w_chk_en    = 1'b1;
                    w_load_st   = B_HDR0;
                    w_load_byte = 8'h30;
                end
            end
        end else begin
            // Bit timing: each bit lasts CLKS_PER_BIT cycles
            if (r_baud == BAUD_MAX) begin
                w_baud = 16'd0;
                case (r_bit_st)
                    T_START: begin
                        w_bit_st  = T_DATA;
                        w_bit_idx = 3'd0;
                        w_tx      = r_shift[0];
                    end
                    T_DATA: begin
                        if (r_bit_idx == 3'd7) begin
                            w_bit_st = T_STOP;
                            w_tx     = 1'b1;
                        end else begin
                            w_bit_idx = r_bit_idx + 3'd1;
                            w_tx      = r_shift[r_bit_idx + 3'd1];
                        end
                    end
                    T_STOP: begin
`ifdef MSG_TX_GAP_EN
                        w_bit_st = T_GAP;
                        w_tx     = 1'b1;
`else
                        w_byte_end = 1'b1;
`endif
                    end
                    default: begin
                        w_byte_end = 1'b1;
                    end
                endcase
            end else begin
                w_baud = r_baud + 16'd1;
            end

            // Byte sequencing; payload reads are issued with the start bit of the preceding byte
            if (w_byte_end) begin
                case (r_byte_st)
                    B_HDR0: begin
                        w_load = 1'b1; w_chk_en = 1'b1;
                        w_load_st = B_HDR1; w_load_byte = 8'h31;
                    end
                    B_HDR1: begin
                        w_load = 1'b1; w_chk_en = 1'b1;
                        w_load_st = B_LEN; w_load_byte = w_len_byte;
                        if (r_len != 10'd0) begin
                            w_mem_en = 1'b1;
                            w_raddr  = 10'd0;
                        end
                    end
                    B_LEN: begin
                        w_load = 1'b1;
                        if (r_len != 10'd0) begin
                            w_chk_en = 1'b1; w_load_st = B_PAY; w_load_byte = r_next;
                            w_pay_cnt = 10'd0;
                            if (r_len > 10'd1) begin
                                w_mem_en = 1'b1;
                                w_raddr  = 10'd1;
                            end
                        end else begin
                            w_load_st = B_CHK; w_load_byte = r_chk;
                        end
                    end
                    B_PAY: begin
                        w_load = 1'b1;
                        if ((r_pay_cnt + 10'd1) < r_len) begin
                            w_chk_en = 1'b1; w_load_st = B_PAY; w_load_byte = r_next;
                            w_pay_cnt = r_pay_cnt + 10'd1;
                            if ((r_pay_cnt + 10'd2) < r_len) begin
                                w_mem_en = 1'b1;
                                w_raddr  = r_pay_cnt + 10'd2;
                            end
                        end else begin
                            w_load_st = B_CHK; w_load_byte = r_chk;
                        end
                    end
                    B_CHK: begin
                        w_load = 1'b1;
                        w_load_st = B_TRL; w_load_byte = 8'h32;
                    end
                    default: begin
                        w_byte_st = B_IDLE;
                        w_busy    = 1'b0;
                        w_done    = 1'b1;
                        w_tx      = 1'b1;
                    end
                endcase
            end
        end

        // Loading a byte starts its start bit and folds it into the checksum when it is frame content
        if (w_load) begin
            w_byte_st = w_load_st;
            w_shift   = w_load_byte;
            w_bit_st  = T_START;
            w_bit_idx = 3'd0;
            w_baud    = 16'd0;
            w_tx      = 1'b0;
            if (w_chk_en) begin
                w_chk = w_chk ^ w_load_byte;
            end
        end
    end

    // State register; reset forces the line idle-high immediately
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_byte_st <= B_IDLE;
            r_bit_st  <= T_START;
            r_baud    <= 16'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_next    <= 8'h00;
            r_chk     <= 8'h00;
            r_len     <= 10'd0;
            r_pay_cnt <= 10'd0;
            r_cap     <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_mem_en  <= 1'b0;
            r_raddr   <= 10'd0;
        end else begin
            r_byte_st <= w_byte_st;
            r_bit_st  <= w_bit_st;
            r_baud    <= w_baud;
            r_bit_idx <= w_bit_idx;
            r_shift   <= w_shift;
            r_next    <= w_next;
            r_chk     <= w_chk;
            r_len     <= w_len;
            r_pay_cnt <= w_pay_cnt;
            r_cap     <= w_cap;
            r_tx      <= w_tx;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_err     <= w_err;
            r_mem_en  <= w_mem_en;
            r_raddr   <= w_raddr;
        end
    end

    assign o_uart_tx   = r_tx;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_mem_en    = r_mem_en;
    assign o_mem_raddr = r_raddr;

endmodule

// File: tb/tb_blk_msg_tx.sv
// Randomized scoreboard bench for blk_msg_tx: a reference frame builder feeds expected
// bytes, read addresses and frame lengths into queues; one monitor decodes the UART
// line and memory port and pops/compares.
module tb_blk_msg_tx;

    localparam int CPB = 8;
`ifdef MSG_TX_GAP_EN
    localparam int BITS = 11;
`else
    localparam int BITS = 10;
`endif
    localparam int BYTE_CYC = BITS * CPB;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_start = 1'b0;
    logic [9:0] i_len = 10'd0;
    logic       o_mem_en;
    logic [9:0] o_mem_raddr;
    logic [7:0] mem_rdata = 8'h00;
    logic       o_uart_tx;
    logic       o_busy;
    logic       o_done;
    logic       o_err;

    blk_msg_tx #(.CLKS_PER_BIT(CPB), .MAX_PAYLOAD(250)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_len       (i_len),
        .o_mem_en    (o_mem_en),
        .o_mem_raddr (o_mem_raddr),
        .i_mem_rdata (mem_rdata),
        .o_uart_tx   (o_uart_tx),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    always #5 i_clk = ~i_clk;

    logic [7:0] mem [0:1023];
    always @(posedge i_clk) if (o_mem_en) mem_rdata <= mem[o_mem_raddr];

    logic [7:0] exp_byte_q [$];
    int         exp_rd_q [$];
    int         exp_frame_q [$];
    int         exp_err = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event seen but nothing was expected", name);
    endtask

    // Reference model: the frame as the host should see it
    task automatic issue(input int len);
        logic [7:0] chk;
        if (len > 250) begin
            exp_err++;
            i_start = 1'b1; i_len = 10'(len);
            @(negedge i_clk);
            check("err_pulse", o_err, 1'b1);
            i_start = 1'b0;
            repeat (3) begin
                @(negedge i_clk);
                check("err_no_busy", o_busy, 1'b0);
                check("err_line_idle", o_uart_tx, 1'b1);
            end
        end else begin
            chk = 8'h30 ^ 8'h31 ^ 8'(len + 5);
            exp_byte_q.push_back(8'h30);
            exp_byte_q.push_back(8'h31);
            exp_byte_q.push_back(8'(len + 5));
            for (int k = 0; k < len; k++) begin
                exp_byte_q.push_back(mem[k]);
                exp_rd_q.push_back(k);
                chk ^= mem[k];
            end
            exp_byte_q.push_back(chk);
            exp_byte_q.push_back(8'h32);
            exp_frame_q.push_back((len + 5) * BYTE_CYC);
            i_start = 1'b1; i_len = 10'(len);
            @(negedge i_clk);
            i_start = 1'b0;
        end
    endtask

    task automatic fill_mem(input int len);
        for (int k = 0; k < len; k++) mem[k] = 8'($urandom);
    endtask

    // Returns on the negedge where o_done is high, so the next request lands in the done cycle
    task automatic wait_done(input int len);
        int limit;
        bit seen;
        limit = (len + 5) * BYTE_CYC + 50;
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge i_clk);
            if (o_done) begin seen = 1'b1; break; end
        end
        if (!seen) begin
            n_cmp++; n_err++;
            $display("FAIL done_timeout: no o_done within %0d cycles", limit);
        end
    endtask

    // Monitor: frame timing, error pulses, memory reads and UART byte decoding
    initial begin
        int cyc, last_start, nbyte, busy_cyc, dst, dcnt, dj;
        logic prev_busy, prev_tx;
        logic [7:0] dsh;
        cyc = 0; last_start = 0; nbyte = 0; busy_cyc = 0; dst = 0; dcnt = 0; dj = 0;
        prev_busy = 1'b0; prev_tx = 1'b1; dsh = 8'h00;
        forever begin
            @(negedge i_clk);
            cyc++;
            if (o_busy && !prev_busy) begin
                check("first_start_low", o_uart_tx, 1'b0);
                busy_cyc = 0;
                nbyte = 0;
            end
            if (o_busy) busy_cyc++;
            if (o_done) begin
                check("done_busy_low", o_busy, 1'b0);
                if (exp_frame_q.size() == 0) fail_event("unexpected_done");
                else check("frame_cycles", busy_cyc, exp_frame_q.pop_front());
            end
            if (o_err) begin
                check("err_expected", exp_err > 0, 1'b1);
                if (exp_err > 0) exp_err--;
            end
            if (o_mem_en) begin
                check("read_on_start_edge", {prev_tx, o_uart_tx}, 2'b10);
                if (exp_rd_q.size() == 0) fail_event("unexpected_read");
                else check("read_addr", o_mem_raddr, exp_rd_q.pop_front());
            end
            if (!i_reset) begin
                dst = 0;
            end else if (dst == 0) begin
                if (o_uart_tx == 1'b0) begin
                    if (nbyte > 0) check("byte_spacing", cyc - last_start, BYTE_CYC);
                    last_start = cyc;
                    nbyte++;
                    dst = 1; dcnt = 0; dj = 0;
                end
            end else begin
                dcnt++;
                if (dcnt == CPB / 2 + dj * CPB) begin
                    if (dj == 0) begin
                        check("start_bit", o_uart_tx, 1'b0);
                    end else if (dj <= 8) begin
                        dsh[dj - 1] = o_uart_tx;
                    end else if (dj == 9) begin
                        check("stop_bit", o_uart_tx, 1'b1);
                    end else begin
                        check("gap_bit", o_uart_tx, 1'b1);
                    end
                    if (dj == BITS - 1) begin
                        dst = 0;
                        if (exp_byte_q.size() == 0) fail_event("unexpected_byte");
                        else check("uart_byte", dsh, exp_byte_q.pop_front());
                    end
                    dj++;
                end
            end
            prev_busy = o_busy;
            prev_tx = o_uart_tx;
        end
    end

    // Stimulus
    initial begin
        int len;
        for (int k = 0; k < 1024; k++) mem[k] = 8'h00;
        repeat (3) @(negedge i_clk);
        check("rst_tx", o_uart_tx, 1'b1);
        check("rst_busy", o_busy, 1'b0);
        check("rst_done", o_done, 1'b0);
        check("rst_err", o_err, 1'b0);
        check("rst_mem_en", o_mem_en, 1'b0);
        check("rst_raddr", o_mem_raddr, 10'd0);
        i_reset = 1'b1;
        repeat (2) @(negedge i_clk);

        // Empty payload, then the two-byte reference frame
        issue(0);
        wait_done(0);
        @(negedge i_clk);
        mem[0] = 8'hAA; mem[1] = 8'h55;
        issue(2);
        wait_done(2);
        @(negedge i_clk);

        // Oversize request rejected, then the largest legal payload
        issue(251);
        fill_mem(250);
        issue(250);
        wait_done(250);
        @(negedge i_clk);

        // Start request during byte 3 of an active frame is ignored
        fill_mem(2);
        issue(2);
        repeat (3 * BYTE_CYC + 2 * CPB) @(negedge i_clk);
        i_start = 1'b1; i_len = 10'd7;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_done(2);
        @(negedge i_clk);

        // Reset in the middle of a payload data bit
        fill_mem(3);
        issue(3);
        repeat (3 * BYTE_CYC + 3 * CPB) @(negedge i_clk);
        @(posedge i_clk);
        #2;
        i_reset = 1'b0;
        exp_byte_q.delete();
        exp_rd_q.delete();
        exp_frame_q.delete();
        #1;
        check("midreset_tx", o_uart_tx, 1'b1);
        check("midreset_busy", o_busy, 1'b0);
        repeat (3) @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        fill_mem(1);
        issue(1);
        wait_done(1);
        @(negedge i_clk);

        // Randomized requests, some oversize, issued right in the done cycle when possible
        for (int t = 0; t < 10; t++) begin
            if ($urandom_range(0, 4) == 0) len = $urandom_range(251, 1023);
            else len = $urandom_range(0, 12);
            fill_mem(len);
            issue(len);
            if (len <= 250) wait_done(len);
        end
        repeat (5) @(negedge i_clk);

        check("bytes_left", exp_byte_q.size(), 0);
        check("reads_left", exp_rd_q.size(), 0);
        check("frames_left", exp_frame_q.size(), 0);
        check("errs_left", exp_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
